// File: rtl/apb_rw_arbiter.sv
// Round-robin arbiter sharing one APB4 requester port between the bridge's write and read paths.
// Optional ACCESS-phase timeout is built in when APB_ARB_TIMEOUT_EN is defined.
module apb_rw_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_req,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_strb,
    input  logic [2:0]            wr_prot,
    output logic                  wr_done,
    output logic                  wr_err,
    input  logic                  rd_req,
    input  logic [ADDR_W-1:0]     rd_addr,
    input  logic [2:0]            rd_prot,
    output logic                  rd_done,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_err,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_W-1:0]     paddr,
    output logic [DATA_W-1:0]     pwdata,
    output logic [DATA_W/8-1:0]   pstrb,
    output logic [2:0]            pprot,
    input  logic                  pready,
    input  logic                  pslverr,
    input  logic [DATA_W-1:0]     prdata,
    output logic                  arb_sel
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t state;
    logic   last_rd;
    logic   grant_rd;

    // On a tie the path that was not served last wins; a lone request always wins.
    assign grant_rd = rd_req && !(wr_req && last_rd);

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             timed_out;
    assign timed_out = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            last_rd <= 1'b1;
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
            pstrb   <= '0;
            pprot   <= '0;
            arb_sel <= 1'b0;
            wr_done <= 1'b0;
            wr_err  <= 1'b0;
            rd_done <= 1'b0;
            rd_data <= '0;
            rd_err  <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
            wait_cnt <= '0;
`endif
        end else begin
            wr_done <= 1'b0;
            rd_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_req || rd_req) begin
                        state   <= SETUP;
                        psel    <= 1'b1;
                        arb_sel <= grant_rd;
                        pwrite  <= !grant_rd;
                        last_rd <= grant_rd;
                        paddr   <= grant_rd ? rd_addr : wr_addr;
                        pprot   <= grant_rd ? rd_prot : wr_prot;
                        pwdata  <= grant_rd ? '0 : wr_data;
                        pstrb   <= grant_rd ? '0 : wr_strb;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    penable <= 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                ACCESS: begin
                    if (pready) begin
                        state   <= RESP;
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        if (arb_sel) begin
                            rd_done <= 1'b1;
                            rd_err  <= pslverr;
                            rd_data <= prdata;
                        end else begin
                            wr_done <= 1'b1;
                            wr_err  <= pslverr;
                        end
                    end
`ifdef APB_ARB_TIMEOUT_EN
                    // A stalled completer is abandoned; the requester sees an error with zero data.
                    else if (timed_out) begin
                        state   <= RESP;
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        if (arb_sel) begin
                            rd_done <= 1'b1;
                            rd_err  <= 1'b1;
                            rd_data <= '0;
                        end else begin
                            wr_done <= 1'b1;
                            wr_err  <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_rw_arbiter.sv
// Self-checking bench for apb_rw_arbiter: directed timing cases plus a randomized run
// scored against a transaction-level round-robin model.
module tb_apb_rw_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;
    localparam int TO     = 4;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              wr_req = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [STRB_W-1:0] wr_strb = '0;
    logic [2:0]        wr_prot = '0;
    logic              wr_done, wr_err;
    logic              rd_req = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [2:0]        rd_prot = '0;
    logic              rd_done, rd_err;
    logic [DATA_W-1:0] rd_data;
    logic              psel, penable, pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [STRB_W-1:0] pstrb;
    logic [2:0]        pprot;
    logic              pready = 1'b0;
    logic              pslverr = 1'b0;
    logic [DATA_W-1:0] prdata = '0;
    logic              arb_sel;

    apb_rw_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rstn(rstn),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb), .wr_prot(wr_prot),
        .wr_done(wr_done), .wr_err(wr_err),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_prot(rd_prot),
        .rd_done(rd_done), .rd_data(rd_data), .rd_err(rd_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pstrb(pstrb), .pprot(pprot), .pready(pready), .pslverr(pslverr), .prdata(prdata),
        .arb_sel(arb_sel)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_mis = 0;
    int          cyc = 0;
    int          ws_cfg = 0;
    logic [31:0] rdata_cfg = '0;
    logic        err_cfg = 1'b0;
    bit          hang = 1'b0;
    int          acc_cnt = 0;
    bit          fired = 1'b0;

    // reference model state for the randomized run
    bit          m_last_rd, g_rd, act_rd, pend, pend_rd, pend_err, exp_wd, exp_rdd;
    logic [31:0] m_rd_data, act_addr, act_wdata, pend_data;
    logic [3:0]  act_strb;
    logic [2:0]  act_prot;
    bit          m_wr_err, m_rd_err;
    int          pend_cyc, wr_wait, rd_wait, n_done;

    int          gcyc[$];
    bit          gsel[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance to the next falling edge and play the APB completer for the coming rising edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        fired = 1'b0;
        if (psel && penable) begin
            if (!hang && acc_cnt >= ws_cfg) begin
                pready  = 1'b1;
                pslverr = err_cfg;
                prdata  = pwrite ? 32'($urandom) : rdata_cfg;
                fired   = 1'b1;
            end else begin
                pready  = 1'b0;
                pslverr = 1'($urandom);
                prdata  = 32'($urandom);
            end
            acc_cnt++;
        end else begin
            pready  = 1'b0;
            pslverr = 1'b0;
            prdata  = '0;
            acc_cnt = 0;
        end
    endtask

    task automatic do_reset();
        wr_req = 1'b0;
        rd_req = 1'b0;
        hang   = 1'b0;
        rstn   = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic wait_done(input bit rd, input int limit, output int k);
        k = 0;
        do begin
            tick();
            k++;
            if (rd && psel) begin
                chk("rd_pstrb_zero", pstrb, 0);
                chk("rd_pwdata_zero", pwdata, 0);
            end
        end while (!(rd ? rd_done : wr_done) && k < limit);
        chk(rd ? "rd_done_seen" : "wr_done_seen", rd ? rd_done : wr_done, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int n_hi;

        // reset state
        rstn = 1'b0;
        tick();
        tick();
        chk("rst_psel", psel, 0);        chk("rst_penable", penable, 0);
        chk("rst_pwrite", pwrite, 0);    chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);    chk("rst_pstrb", pstrb, 0);
        chk("rst_pprot", pprot, 0);      chk("rst_arb_sel", arb_sel, 0);
        chk("rst_wr_done", wr_done, 0);  chk("rst_wr_err", wr_err, 0);
        chk("rst_rd_done", rd_done, 0);  chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_err", rd_err, 0);
        rstn = 1'b1;
        tick();
        chk("idle_psel", psel, 0);

        // single zero-wait write
        wr_addr = 32'h10; wr_data = 32'hA5A5_0001; wr_strb = 4'hF; wr_prot = 3'b001;
        ws_cfg = 0; err_cfg = 1'b0; wr_req = 1'b1;
        tick();
        chk("wr_setup_psel", psel, 1);    chk("wr_setup_penable", penable, 0);
        chk("wr_pwrite", pwrite, 1);      chk("wr_paddr", paddr, 32'h10);
        chk("wr_pwdata", pwdata, 32'hA5A5_0001);
        chk("wr_pstrb", pstrb, 4'hF);     chk("wr_pprot", pprot, 3'b001);
        chk("wr_arb_sel", arb_sel, 0);
        tick();
        chk("wr_access_psel", psel, 1);   chk("wr_access_penable", penable, 1);
        chk("wr_early_done", wr_done, 0);
        tick();
        chk("wr_done", wr_done, 1);       chk("wr_err", wr_err, 0);
        chk("wr_resp_psel", psel, 0);     chk("wr_rd_untouched", rd_done, 0);
        wr_req = 1'b0;
        tick();
        chk("wr_done_pulse", wr_done, 0); chk("wr_paddr_hold", paddr, 32'h10);
        chk("wr_rd_data_hold", rd_data, 0);

        // read with three wait states and an error response
        rd_addr = 32'h20; rd_prot = 3'b010; ws_cfg = 3; rdata_cfg = 32'hDEAD_BEEF; err_cfg = 1'b1;
        rd_req = 1'b1;
        wait_done(1'b1, 20, k);
        chk("rd_latency", k, 6);
        chk("rd_data", rd_data, 32'hDEAD_BEEF);
        chk("rd_err", rd_err, 1);
        chk("rd_arb_sel", arb_sel, 1);
        chk("rd_pprot", pprot, 3'b010);
        rd_req = 1'b0;
        tick();
        chk("rd_done_pulse", rd_done, 0);
        chk("rd_data_hold", rd_data, 32'hDEAD_BEEF);
        chk("rd_wr_err_hold", wr_err, 0);

        // both paths held: grants alternate W,R,... every 4 cycles
        do_reset();
        ws_cfg = 0; err_cfg = 1'b0;
        wr_addr = 32'h100; wr_data = 32'h1; wr_strb = 4'h3;
        rd_addr = 32'h200;
        wr_req = 1'b1; rd_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (psel && !penable) begin
                gcyc.push_back(cyc);
                gsel.push_back(arb_sel);
            end
            if (wr_done) begin wr_addr += 4; wr_data = $urandom; end
            if (rd_done) rd_addr += 4;
        end
        chk("alt_grant_count", gcyc.size() >= 6, 1);
        for (int i = 0; i < 6 && i < gcyc.size(); i++) begin
            chk("alt_sel", gsel[i], i % 2);
            if (i > 0) chk("alt_gap", gcyc[i] - gcyc[i-1], 4);
        end

        // reset during ACCESS of a write, then a normal read
        do_reset();
        hang = 1'b1; wr_addr = 32'h40; wr_data = 32'h5; wr_strb = 4'hF; wr_req = 1'b1;
        tick();
        tick();
        tick();
        chk("rst_mid_penable_before", penable, 1);
        #2 rstn = 1'b0;
        #1;
        chk("rst_mid_psel", psel, 0);
        chk("rst_mid_penable", penable, 0);
        chk("rst_mid_wr_done", wr_done, 0);
        wr_req = 1'b0; hang = 1'b0;
        tick();
        rstn = 1'b1;
        rd_addr = 32'h30; rd_prot = 3'b000; ws_cfg = 1; rdata_cfg = 32'h1234_5678; err_cfg = 1'b0;
        rd_req = 1'b1;
        wait_done(1'b1, 20, k);
        chk("rst_rd_latency", k, 4);
        chk("rst_rd_data", rd_data, 32'h1234_5678);
        chk("rst_rd_err", rd_err, 0);
        chk("rst_no_wr_done", wr_done, 0);
        rd_req = 1'b0;
        tick();

        // completer never answers
        hang = 1'b1; rd_addr = 32'h60; rdata_cfg = 32'hCAFE_F00D; rd_req = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
        wait_done(1'b1, 20, k);
        chk("to_latency", k, 2 + TO);
        chk("to_rd_err", rd_err, 1);
        chk("to_rd_data", rd_data, 0);
        chk("to_psel", psel, 0);
        rd_req = 1'b0; hang = 1'b0;
`else
        tick();
        n_hi = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (psel && !rd_done) n_hi++;
        end
        chk("no_timeout_psel_held", n_hi, 100);
        hang = 1'b0;
        wait_done(1'b1, 10, k);
        chk("late_rd_data", rd_data, 32'hCAFE_F00D);
        rd_req = 1'b0;
`endif
        tick();

        // randomized traffic against the transaction-level model
        do_reset();
        m_last_rd = 1'b1; m_rd_data = '0; m_wr_err = 1'b0; m_rd_err = 1'b0;
        pend = 1'b0; act_rd = 1'b0; act_addr = '0; act_wdata = '0; act_strb = '0; act_prot = '0;
        wr_wait = 0; rd_wait = 0; n_done = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (fired) begin
                pend = 1'b1; pend_cyc = cyc + 1; pend_rd = act_rd;
                pend_err = pslverr; pend_data = prdata;
            end
            if (psel && !penable) begin
                g_rd = rd_req && !(wr_req && m_last_rd);
                chk("rnd_grant_sel", arb_sel, g_rd);
                chk("rnd_grant_had_req", g_rd ? rd_req : wr_req, 1);
                act_rd    = g_rd;
                act_addr  = g_rd ? rd_addr : wr_addr;
                act_wdata = g_rd ? 32'h0 : wr_data;
                act_strb  = g_rd ? 4'h0 : wr_strb;
                act_prot  = g_rd ? rd_prot : wr_prot;
                m_last_rd = g_rd;
                ws_cfg    = $urandom_range(0, 3);
                rdata_cfg = $urandom;
                err_cfg   = 1'($urandom);
            end
            if (psel) begin
                chk("rnd_pwrite", pwrite, !act_rd);
                chk("rnd_paddr", paddr, act_addr);
                chk("rnd_pwdata", pwdata, act_wdata);
                chk("rnd_pstrb", pstrb, act_strb);
                chk("rnd_pprot", pprot, act_prot);
            end
            exp_wd  = pend && !pend_rd && cyc == pend_cyc;
            exp_rdd = pend && pend_rd && cyc == pend_cyc;
            chk("rnd_wr_done", wr_done, exp_wd);
            chk("rnd_rd_done", rd_done, exp_rdd);
            if (exp_rdd) begin
                m_rd_data = pend_data; m_rd_err = pend_err;
                chk("rnd_rd_wait_bound", rd_wait <= 20, 1);
                rd_wait = 0; n_done++; pend = 1'b0;
                rd_req = 1'($urandom);
                if (rd_req) begin rd_addr = $urandom; rd_prot = 3'($urandom); end
            end
            if (exp_wd) begin
                m_wr_err = pend_err;
                chk("rnd_wr_wait_bound", wr_wait <= 20, 1);
                wr_wait = 0; n_done++; pend = 1'b0;
                wr_req = 1'($urandom);
                if (wr_req) begin
                    wr_addr = $urandom; wr_data = $urandom; wr_strb = 4'($urandom); wr_prot = 3'($urandom);
                end
            end
            chk("rnd_wr_err", wr_err, m_wr_err);
            chk("rnd_rd_err", rd_err, m_rd_err);
            chk("rnd_rd_data", rd_data, m_rd_data);
            if (!wr_req && $urandom_range(0, 2) == 0) begin
                wr_req = 1'b1;
                wr_addr = $urandom; wr_data = $urandom; wr_strb = 4'($urandom); wr_prot = 3'($urandom);
            end
            if (!rd_req && $urandom_range(0, 2) == 0) begin
                rd_req = 1'b1;
                rd_addr = $urandom; rd_prot = 3'($urandom);
            end
            if (wr_req) wr_wait++;
            if (rd_req) rd_wait++;
        end
        chk("rnd_final_wr_wait", wr_wait <= 20, 1);
        chk("rnd_final_rd_wait", rd_wait <= 20, 1);
        chk("rnd_activity", n_done > 100, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/apb_rw_arbiter.md
Name: apb_rw_arbiter

Overview:
- Shares one APB4 requester port between the AXI4-Lite write path and read path of the AXI4Lite-to-APB4 bridge.
- Arbitrates round-robin between the two requesters and sequences the APB4 SETUP/ACCESS phases.
- Drives arb_sel, the select line for the bridge's 2:1 request mux and 1:2 response decoder.
- Returns a one-cycle completion pulse with response data and status to the requester that was served.

Parameters:
- ADDR_W, 32, address width of requesters and paddr.
- DATA_W, 32, data width; must be a multiple of 8.
- TIMEOUT_CYCLES, 255, ACCESS-phase wait limit; used only with the optional feature.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- wr_req  in  1  write request, level; held with payload until wr_done
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_strb  in  DATA_W/8  write byte strobes
- wr_prot  in  3  write protection
- wr_done  out  1  one-cycle write completion pulse
- wr_err  out  1  write error, valid with wr_done
- rd_req  in  1  read request, level; held with payload until rd_done
- rd_addr  in  ADDR_W  read address
- rd_prot  in  3  read protection
- rd_done  out  1  one-cycle read completion pulse
- rd_data  out  DATA_W  read data, valid with rd_done
- rd_err  out  1  read error, valid with rd_done
- psel, penable, pwrite  out  1 each  APB4 control
- paddr  out  ADDR_W  APB4 address
- pwdata  out  DATA_W  APB4 write data
- pstrb  out  DATA_W/8  APB4 strobes
- pprot  out  3  APB4 protection
- pready, pslverr  in  1 each  APB4 completer response
- prdata  in  DATA_W  APB4 read data
- arb_sel  out  1  0 = write path, 1 = read path

Behaviour:
- Reset values: all outputs 0 (including arb_sel); last_served = read, so write wins the first tie; state = IDLE.
- All outputs are registered.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - Samples wr_req and rd_req.
  - One request active: grant it.
  - Both active: grant the requester not in last_served.
  - On grant: next state SETUP; load arb_sel, pwrite, paddr, pprot, pwdata, pstrb from the granted requester; update last_served.
  - For a read, pwdata = 0 and pstrb = 0.
- SETUP: psel = 1, penable = 0; next state ACCESS unconditionally.
- ACCESS:
  - psel = 1, penable = 1.
  - While pready = 0: remain in ACCESS; all APB outputs stable.
  - When pready = 1: capture pslverr into the granted requester's err output; for a read, capture prdata into rd_data; next state RESP.
- RESP:
  - psel = 0, penable = 0.
  - The granted requester's done = 1 for exactly this cycle, with err/data valid.
  - Next state IDLE unconditionally.
- Latency: request seen in IDLE at cycle N → SETUP at N+1, ACCESS at N+2. With pready = 1 at cycle M, done fires at M+1.
- Minimum spacing of back-to-back transfers: 4 cycles.
- Requester rule: req must be deasserted, or re-presented with a new payload, in the cycle after done. Requests are not sampled during RESP.
- rd_data and wr_err/rd_err hold their values until the next completion to the same requester.
- paddr, pwdata, pstrb, pprot and arb_sel hold their values through IDLE.
- Request withdrawn after grant: ignored; the transfer completes.
- Reset mid-transfer: psel/penable drop asynchronously; no done is issued; the FSM returns to IDLE.

Optional Feature:
- Macro: APB_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with pready = 0.
  - When it reaches TIMEOUT_CYCLES, go to RESP with err = 1 and rd_data = 0; the late pready is ignored.
  - A timeout ends the transfer; last_served stays updated.
- Undefined: no counter; ACCESS waits indefinitely for pready.

Test Plan:
- Single write, addr 0x10, data 0xA5A5_0001, strb 0xF, pready high on the first ACCESS cycle → psel at N+1, penable at N+2, pwrite = 1, pstrb = 0xF, wr_done pulse at N+3, wr_err = 0, arb_sel = 0.
- Single read, addr 0x20, pready after 3 wait states, prdata 0xDEAD_BEEF, pslverr = 1 → rd_done at N+6, rd_data = 0xDEAD_BEEF, rd_err = 1, pstrb = 0 and pwdata = 0 throughout.
- wr_req and rd_req both held continuously, re-presented after each done → grants alternate W, R, W, R after reset; SETUP starts every 4 cycles with zero-wait pready.
- Assert rstn low during ACCESS of a write → psel, penable, wr_done all 0 immediately; after release, a new read completes normally.
- With APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 4, pready held at 0 → RESP after 4 wait cycles, rd_done with rd_err = 1, rd_data = 0, psel drops; without the macro, psel stays high for 100 cycles.
